// File: rtl/ldxa_scan_ctrl_if.sv
// Host-side bundle for the ldxa sweep controller:
// scan request/abort in, status and signature out.
interface ldxa_scan_ctrl_if;
  logic       start;
  logic       abort;
  logic [7:0] expected;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [7:0] mismatch;
  logic       pass;

  modport master (
    output start, abort, expected,
    input  busy, done, result, mismatch, pass
  );

  modport slave (
    input  start, abort, expected,
    output busy, done, result, mismatch, pass
  );
endinterface

// File: rtl/ldxa_scan_ctrl.sv
// Sweeps all eight {D,X,A} vectors into one ldxa
// instance and builds its 8-bit truth-table signature.
module ldxa_scan_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  ldxa_scan_ctrl_if.slave host,
  input  logic            l_in,
  output logic            d_out,
  output logic            x_out,
  output logic            a_out
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SLAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SAMPLE,
    DONE
  } state_t;

  state_t        state;
  logic [2:0]    vec;
  logic [SW-1:0] settle;
  logic [7:0]    exp_q;
  logic [2:0]    dxa;
  logic          busy;
  logic          done;
  logic [7:0]    result;
  logic [7:0]    mismatch;
  logic          pass;
  logic [7:0]    res_cap;

  // Signature as it stands once this cycle's sample lands.
  always_comb begin
    res_cap      = result;
    res_cap[vec] = l_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      vec      <= '0;
      settle   <= '0;
      exp_q    <= '0;
      dxa      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      mismatch <= '0;
      pass     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (host.start) begin
            exp_q    <= host.expected;
            result   <= '0;
            mismatch <= '0;
            pass     <= 1'b0;
            vec      <= '0;
            settle   <= '0;
            dxa      <= '0;
            busy     <= 1'b1;
            state    <= APPLY;
          end
        end
        APPLY: begin
          if (host.abort) begin
            state  <= IDLE;
            busy   <= 1'b0;
            dxa    <= '0;
            vec    <= '0;
            settle <= '0;
          end else if (settle == SLAST) begin
            state <= SAMPLE;
          end else begin
            settle <= settle + SW'(1);
          end
        end
        SAMPLE: begin
          if (host.abort) begin
            state  <= IDLE;
            busy   <= 1'b0;
            dxa    <= '0;
            vec    <= '0;
            settle <= '0;
          end else begin
            result <= res_cap;
            if (vec == 3'd7) begin
              state    <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              dxa      <= '0;
              mismatch <= res_cap ^ exp_q;
              pass     <= (res_cap == exp_q);
            end else begin
              vec    <= vec + 3'd1;
              dxa    <= vec + 3'd1;
              settle <= '0;
              state  <= APPLY;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          vec   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign {d_out, x_out, a_out} = dxa;
  assign host.busy     = busy;
  assign host.done     = done;
  assign host.result   = result;
  assign host.mismatch = mismatch;
  assign host.pass     = pass;

endmodule

// File: tb/tb_ldxa_scan_ctrl.sv
// Bench for ldxa_scan_ctrl: two instances (S=2, S=1) driven
// against a cycle-count model of the sweep timing.
module tb_ldxa_scan_ctrl;

  localparam int S0 = 2;
  localparam int S1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] st;
  logic [1:0] ab;
  logic [1:0] lm;
  logic [7:0] ex [2];
  logic d0, x0, a0, l0;
  logic d1, x1, a1, l1;

  int total  = 0;
  int passed = 0;

  ldxa_scan_ctrl_if if0 ();
  ldxa_scan_ctrl_if if1 ();

  assign if0.start    = st[0];
  assign if0.abort    = ab[0];
  assign if0.expected = ex[0];
  assign if1.start    = st[1];
  assign if1.abort    = ab[1];
  assign if1.expected = ex[1];

  // ldxa under test, or tied high when lm is set
  assign l0 = lm[0] | (d0 & (x0 | a0));
  assign l1 = lm[1] | (d1 & (x1 | a1));

  ldxa_scan_ctrl #(.SETTLE_CYCLES(S0)) dut0 (
    .clk(clk), .rst_n(rst_n), .host(if0),
    .l_in(l0), .d_out(d0), .x_out(x0), .a_out(a0)
  );

  ldxa_scan_ctrl #(.SETTLE_CYCLES(S1)) dut1 (
    .clk(clk), .rst_n(rst_n), .host(if1),
    .l_in(l1), .d_out(d1), .x_out(x1), .a_out(a1)
  );

  function automatic int sv(input int w);
    return (w == 0) ? S0 : S1;
  endfunction

  function automatic logic ttb(input logic m, input int n);
    logic [2:0] v;
    v = 3'(n);
    return m | (v[2] & (v[1] | v[0]));
  endfunction

  function automatic logic [7:0] tt(input logic m);
    logic [7:0] t;
    for (int n = 0; n < 8; n++) t[n] = ttb(m, n);
    return t;
  endfunction

  // Model: mk = cycles since start acceptance (0 = idle).
  int         mk    [2];
  logic [7:0] mres  [2];
  logic [7:0] mmm   [2];
  logic [7:0] mexp  [2];
  logic       mpass [2];

  always @(posedge clk or negedge rst_n) begin
    for (int w = 0; w < 2; w++) begin
      if (!rst_n) begin
        mk[w]    <= 0;
        mres[w]  <= '0;
        mmm[w]   <= '0;
        mexp[w]  <= '0;
        mpass[w] <= 1'b0;
      end else if (mk[w] == 0) begin
        if (st[w]) begin
          mk[w]    <= 1;
          mexp[w]  <= ex[w];
          mres[w]  <= '0;
          mmm[w]   <= '0;
          mpass[w] <= 1'b0;
        end
      end else if (mk[w] <= 8 * (sv(w) + 1)) begin
        if (ab[w]) begin
          mk[w] <= 0;
        end else begin
          if (mk[w] % (sv(w) + 1) == 0)
            mres[w][3'(mk[w] / (sv(w) + 1) - 1)] <=
              ttb(lm[w], mk[w] / (sv(w) + 1) - 1);
          if (mk[w] == 8 * (sv(w) + 1)) begin
            mmm[w]   <= tt(lm[w]) ^ mexp[w];
            mpass[w] <= (tt(lm[w]) == mexp[w]);
          end
          mk[w] <= mk[w] + 1;
        end
      end else begin
        mk[w] <= 0;
      end
    end
  end

  // {vec[21:19], busy[18], done[17], result[16:9], mismatch[8:1], pass[0]}
  function automatic logic [21:0] expv(input int w);
    int         k;
    logic       bsy;
    logic [2:0] v;
    k   = mk[w];
    bsy = (k >= 1) && (k <= 8 * (sv(w) + 1));
    v   = bsy ? 3'((k - 1) / (sv(w) + 1)) : 3'd0;
    return {v, bsy, (k == 8 * (sv(w) + 1) + 1),
            mres[w], mmm[w], mpass[w]};
  endfunction

  function automatic logic [21:0] act(input int w);
    if (w == 0)
      return {d0, x0, a0, if0.busy, if0.done,
              if0.result, if0.mismatch, if0.pass};
    return {d1, x1, a1, if1.busy, if1.done,
            if1.result, if1.mismatch, if1.pass};
  endfunction

  always @(negedge clk) begin
    for (int w = 0; w < 2; w++) begin
      total++;
      if (act(w) === expv(w)) passed++;
      else $display("FAIL model_cmp dut%0d t=%0t got %h want %h",
                    w, $time, act(w), expv(w));
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s got %0h want %0h", nm, got, want);
  endtask

  // Call at posedge+2 of the cycle that becomes cycle 0.
  task automatic run(input int w, input logic [7:0] e,
                     input int p1, input int p2, input int p3,
                     input int ab_at, input int lim,
                     output int dcyc, output int ndone,
                     output logic [7:0] r, output logic [7:0] m,
                     output logic p);
    logic [21:0] a;
    ex[w] = e;
    st[w] = 1'b1;
    ab[w] = 1'b0;
    dcyc  = -1;
    ndone = 0;
    r = '0; m = '0; p = 1'b0;
    for (int c = 1; c <= lim; c++) begin
      @(posedge clk);
      #2;
      st[w] = (c == p1) || (c == p2) || (c == p3);
      ab[w] = (c == ab_at);
      a = act(w);
      if (a[17]) begin
        ndone++;
        if (dcyc < 0) begin
          dcyc = c;
          r = a[16:9];
          m = a[8:1];
          p = a[0];
        end
      end
    end
    st[w] = 1'b0;
    ab[w] = 1'b0;
  endtask

  int         dc, nd;
  logic [7:0] r, m;
  logic       p;
  logic [21:0] a;

  initial begin
    rst_n = 1'b0;
    st = '0; ab = '0; lm = '0;
    ex[0] = '0; ex[1] = '0;
    #1;
    chk("reset_outputs_dut0", 32'(act(0)), 32'd0);
    chk("reset_outputs_dut1", 32'(act(1)), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    run(0, 8'hE0, 0, 0, 0, 0, 26, dc, nd, r, m, p);
    chk("pass_done_cycle", 32'(dc), 32'd25);
    chk("pass_result", 32'(r), 32'hE0);
    chk("pass_mismatch", 32'(m), 32'h00);
    chk("pass_flag", 32'(p), 32'd1);

    run(0, 8'hF0, 0, 0, 0, 0, 26, dc, nd, r, m, p);
    chk("fail_done_cycle", 32'(dc), 32'd25);
    chk("fail_result", 32'(r), 32'hE0);
    chk("fail_mismatch", 32'(m), 32'h10);
    chk("fail_flag", 32'(p), 32'd0);

    run(0, 8'hE0, 5, 24, 26, 0, 28, dc, nd, r, m, p);
    chk("ignored_start_done_cycle", 32'(dc), 32'd25);
    chk("ignored_start_done_count", 32'(nd), 32'd1);
    chk("restart_busy", 32'(if0.busy), 32'd1);
    repeat (30) begin
      @(posedge clk);
      #2;
    end

    run(0, 8'hE0, 0, 0, 0, 12, 13, dc, nd, r, m, p);
    a = act(0);
    chk("abort_no_done", 32'(nd), 32'd0);
    chk("abort_idle_outputs", 32'({a[21:17], a[0]}), 32'd0);
    chk("abort_result", 32'(a[16:9]), 32'h00);

    lm[0] = 1'b1;
    run(0, 8'hFF, 0, 0, 0, 12, 13, dc, nd, r, m, p);
    a = act(0);
    chk("abort1_no_done", 32'(nd), 32'd0);
    chk("abort1_result", 32'(a[16:9]), 32'h07);
    chk("abort1_pass", 32'(a[0]), 32'd0);

    run(0, 8'hFF, 0, 0, 0, 0, 16, dc, nd, r, m, p);
    a = act(0);
    chk("pre_reset_vec", 32'(a[21:19]), 32'd5);
    chk("pre_reset_result", 32'(a[16:9]), 32'h1F);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'(act(0)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lm[0] = 1'b0;
    @(posedge clk);
    #2;
    run(0, 8'hE0, 0, 0, 0, 0, 26, dc, nd, r, m, p);
    chk("post_reset_done_cycle", 32'(dc), 32'd25);
    chk("post_reset_pass", 32'(p), 32'd1);

    lm[1] = 1'b1;
    run(1, 8'hFF, 0, 0, 0, 0, 18, dc, nd, r, m, p);
    chk("s1_done_cycle", 32'(dc), 32'd17);
    chk("s1_result", 32'(r), 32'hFF);
    chk("s1_pass", 32'(p), 32'd1);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
